// File: rtl/vote_collector.sv
// vote_collector
//   Sequential front-end for the 5-bit majority voter. Single-bit votes arrive
//   over a valid/ready handshake and are packed into a 5-bit ballot. Bit k of
//   the ballot holds the k-th accepted vote. When the fifth vote lands, the
//   ballot register is updated and ballot_valid pulses for one cycle, so the
//   downstream majority stage can sample it. A partial ballot is discarded by
//   clear or, optionally, by an inactivity timeout.
//
//   Optional feature macro: VOTE_TIMEOUT_EN (inactivity timeout in COLLECT).
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   vote_in      in   vote value, qualified by vote_valid
//   vote_valid   in   producer has a vote on vote_in
//   vote_ready   out  collector can accept a vote this cycle (combinational)
//   clear        in   synchronous abort of the current partial ballot
//   ballot[4:0]  out  last completed ballot
//   ballot_valid out  one-cycle strobe: ballot was just updated
//   count[2:0]   out  votes accepted into the current ballot (0..5)
//   timeout      out  one-cycle strobe: partial ballot dropped by timeout
module vote_collector #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vote_in,
  input  logic       vote_valid,
  output logic       vote_ready,
  input  logic       clear,
  output logic [4:0] ballot,
  output logic       ballot_valid,
  output logic [2:0] count,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // The idle limit is an 8-bit quantity; reject out-of-range settings early.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("vote_collector: TIMEOUT must be in 1..255");
  end

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [4:0] shadow_q, shadow_d;
  logic [4:0] ballot_q, ballot_d;
  logic       bv_q, bv_d;
  logic       accept;

`ifdef VOTE_TIMEOUT_EN
  // Comparing against TIMEOUT-1 makes the limit "reached" in the TIMEOUT-th
  // idle cycle, so an accept in that same cycle can still win.
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
  logic [7:0] idle_q, idle_d;
  logic       timeout_q, timeout_d;
`endif

  assign vote_ready = (state_q != DONE) && !clear;
  assign accept     = vote_valid && vote_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    ballot_d = ballot_q;
    bv_d     = 1'b0;
`ifdef VOTE_TIMEOUT_EN
    // Idle counter restarts on every accept, on state entry and outside COLLECT.
    idle_d    = 8'd0;
    timeout_d = 1'b0;
`endif
    if (clear) begin
      // Abort wins over a simultaneous vote and over a pending timeout.
      state_d  = IDLE;
      count_d  = 3'd0;
      shadow_d = 5'd0;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          if (accept) begin
            shadow_d[count_q] = vote_in;
            count_d           = count_q + 3'd1;
            if (count_q == 3'd4) begin
              // Fifth vote is merged before the copy so it lands in ballot.
              state_d  = DONE;
              ballot_d = shadow_d;
              bv_d     = 1'b1;
            end else begin
              state_d = COLLECT;
            end
          end
`ifdef VOTE_TIMEOUT_EN
          else if (state_q == COLLECT) begin
            if (idle_q == IDLE_LAST) begin
              state_d   = IDLE;
              count_d   = 3'd0;
              shadow_d  = 5'd0;
              timeout_d = 1'b1;
            end else begin
              idle_d = idle_q + 8'd1;
            end
          end
`endif
        end
        DONE: begin
          state_d  = IDLE;
          count_d  = 3'd0;
          shadow_d = 5'd0;
        end
        default: begin
          state_d  = IDLE;
          count_d  = 3'd0;
          shadow_d = 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 3'd0;
      shadow_q <= 5'd0;
      ballot_q <= 5'd0;
      bv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      ballot_q <= ballot_d;
      bv_q     <= bv_d;
    end
  end

`ifdef VOTE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign ballot       = ballot_q;
  assign ballot_valid = bv_q;
  assign count        = count_q;

endmodule

// File: tb/tb_vote_collector.sv
// Testbench for vote_collector: table of directed vectors (inputs, expected
// combinational vote_ready before the edge, expected registered outputs after
// the edge), followed by hand-written multi-cycle sequences for reset in the
// middle of a ballot and the inactivity timeout.
module tb_vote_collector;

  logic       clk = 1'b0;
  logic       reset, vote_in, vote_valid, clear;
  logic       vote_ready, ballot_valid, timeout;
  logic [4:0] ballot;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  vote_collector #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .vote_in      (vote_in),
    .vote_valid   (vote_valid),
    .vote_ready   (vote_ready),
    .clear        (clear),
    .ballot       (ballot),
    .ballot_valid (ballot_valid),
    .count        (count),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vi;
    logic       vv;
    logic       cl;
    logic       rdy;
    logic [4:0] bal;
    logic       bv;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vi, input logic vv, input logic cl,
                     input logic rdy, input logic [4:0] bal, input logic bv,
                     input logic [2:0] cnt);
    vec_t v;
    v.vi = vi; v.vv = vv; v.cl = cl;
    v.rdy = rdy; v.bal = bal; v.bv = bv; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vi, input logic vv, input logic cl);
    vote_in = vi; vote_valid = vv; clear = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] bal, input logic bv,
                         input logic [2:0] cnt, input logic to);
    chk({tag, ".ballot"},       int'(ballot),       int'(bal));
    chk({tag, ".ballot_valid"}, int'(ballot_valid), int'(bv));
    chk({tag, ".count"},        int'(count),        int'(cnt));
    chk({tag, ".timeout"},      int'(timeout),      int'(to));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Basic ballot 1,0,1,1,0 -> 5'b01101
    add(1, 1, 0, 1, 5'b00000, 0, 3'd1);
    add(0, 1, 0, 1, 5'b00000, 0, 3'd2);
    add(1, 1, 0, 1, 5'b00000, 0, 3'd3);
    add(1, 1, 0, 1, 5'b00000, 0, 3'd4);
    add(0, 1, 0, 1, 5'b01101, 1, 3'd5);
    add(0, 0, 0, 0, 5'b01101, 0, 3'd0);
    // 1,1,0 then clear, then five zeros
    add(1, 1, 0, 1, 5'b01101, 0, 3'd1);
    add(1, 1, 0, 1, 5'b01101, 0, 3'd2);
    add(0, 1, 0, 1, 5'b01101, 0, 3'd3);
    add(0, 0, 1, 0, 5'b01101, 0, 3'd0);
    for (int i = 1; i <= 4; i++) add(0, 1, 0, 1, 5'b01101, 0, 3'(i));
    add(0, 1, 0, 1, 5'b00000, 1, 3'd5);
    add(0, 0, 0, 0, 5'b00000, 0, 3'd0);
    // vote_valid held high with vote_in=1 for 12 cycles
    for (int b = 0; b < 2; b++) begin
      for (int i = 1; i <= 4; i++)
        add(1, 1, 0, 1, (b == 0) ? 5'b00000 : 5'b11111, 0, 3'(i));
      add(1, 1, 0, 1, 5'b11111, 1, 3'd5);
      add(1, 1, 0, 0, 5'b11111, 0, 3'd0);
    end
    // clear together with a vote at count=2
    add(1, 1, 0, 1, 5'b11111, 0, 3'd1);
    add(1, 1, 0, 1, 5'b11111, 0, 3'd2);
    add(1, 1, 1, 0, 5'b11111, 0, 3'd0);
    add(1, 1, 0, 1, 5'b11111, 0, 3'd1);
    for (int i = 2; i <= 4; i++) add(0, 1, 0, 1, 5'b11111, 0, 3'(i));
    add(0, 1, 0, 1, 5'b00001, 1, 3'd5);
    add(0, 0, 0, 0, 5'b00001, 0, 3'd0);
    // clear during DONE: strobe already out, next cycle clean
    for (int i = 1; i <= 4; i++) add(1, 1, 0, 1, 5'b00001, 0, 3'(i));
    add(1, 1, 0, 1, 5'b11111, 1, 3'd5);
    add(1, 1, 1, 0, 5'b11111, 0, 3'd0);
    add(0, 0, 0, 1, 5'b11111, 0, 3'd0);

    // Reset state
    tick();
    tick();
    chk_out("reset", 5'b00000, 1'b0, 3'd0, 1'b0);
    reset = 1'b0;
    #1;
    chk("reset.vote_ready", int'(vote_ready), 1);

    foreach (tbl[k]) begin
      drive(tbl[k].vi, tbl[k].vv, tbl[k].cl);
      #1;
      chk($sformatf("vec%0d.vote_ready", k), int'(vote_ready), int'(tbl[k].rdy));
      tick();
      chk_out($sformatf("vec%0d", k), tbl[k].bal, tbl[k].bv, tbl[k].cnt, 1'b0);
    end

    // Reset at count=3 discards the ballot without a strobe
    drive(1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    chk("midrst.pre_count", int'(count), 3);
    reset = 1'b1;
    tick();
    chk_out("midrst", 5'b00000, 1'b0, 3'd0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("midrst.vote_ready", int'(vote_ready), 1);
    tick();
    chk_out("midrst.after", 5'b00000, 1'b0, 3'd0, 1'b0);

`ifdef VOTE_TIMEOUT_EN
    // Two votes, then four idle cycles -> timeout strobe
    drive(1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_out($sformatf("to.idle%0d", i), 5'b00000, 1'b0, 3'd2, 1'b0);
    end
    tick();
    chk_out("to.fire", 5'b00000, 1'b0, 3'd0, 1'b1);
    tick();
    chk_out("to.after", 5'b00000, 1'b0, 3'd0, 1'b0);
    // Same, but a vote on the fourth idle cycle wins
    drive(1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    drive(1'b1, 1'b1, 1'b0);
    tick();
    chk_out("to.save", 5'b00000, 1'b0, 3'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    chk_out("to.save_next", 5'b00000, 1'b0, 3'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
`else
    // Without the timeout feature a partial ballot waits indefinitely
    drive(1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_out($sformatf("nto.idle%0d", i), 5'b00000, 1'b0, 3'd2, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
